alu_wide_seq: RTL and testbench
===============================

// Module: alu_wide_seq
// PURPOSE
//  Issue side of the 8-bit ALU interface: drives InputA/InputB/OP and consumes Out/Over.
//  Runs 16-bit ADD, SHL1, SHR1 and MOV as three 8-bit ALU ops, using Over as the inter-byte carry.
//  Sits between decode and the shared ALU. The ALU is combinational: each step's result is captured on the next CLK edge.
// PARAMETERS
//  W        8        ALU data width; fixed at 8, 16-bit result = {hi,lo}
//  IDLE_OP  4'b0111  ALU opcode driven when not busy (MOV, no side effect)
// PORTS
//  CLK       in   1   clock, rising edge
//  Reset     in   1   asynchronous, active-high; clears all state
//  Start     in   1   request; accepted only on an edge where Busy=0
//  Cmd       in   2   00 ADD16, 01 SHL16 by 1, 10 SHR16 by 1, 11 MOV16 (result = OpA)
//  OpA       in   16  operand A; latched on accept
//  OpB       in   16  operand B; latched on accept; ignored by SHL/SHR/MOV
//  AluA      out  8   to ALU InputA
//  AluB      out  8   to ALU InputB
//  AluOp     out  4   to ALU OP
//  AluOut    in   8   from ALU Out
//  AluOver   in   1   from ALU Over
//  Result    out  16  registered 16-bit result, held until the next completion
//  CarryOut  out  1   registered carry/shifted-out bit (feeds reg 12 write)
//  Busy      out  1   high in S1..S3
//  Done      out  1   one-cycle pulse, the cycle after the S3 capture edge
// BEHAVIOUR
//  Reset: state IDLE; Result=0, CarryOut=0, Busy=0, Done=0, AluA=0, AluB=0, AluOp=IDLE_OP.
//  FSM: IDLE -(Start)-> S1 -> S2 -> S3 -> IDLE. Done=1 in the first IDLE cycle after S3.
//  Start at edge E0. S1/S2/S3 results are captured at E1/E2/E3.
//  Result, CarryOut and Done are visible after E3. Latency is 3 cycles; throughput is 1 op / 3 cycles.
//  Start during Busy is ignored: no queuing, latched operands unchanged. Start in the Done cycle is accepted.
//  Alu* outputs are combinational from state and latched operands. In IDLE they are 0/0/IDLE_OP.
//  ADD16: S1 op 0000 (A_lo,B_lo) -> lo, c=Over. S2 op 0000 (A_hi,B_hi) -> t, k=Over.
//         S3 op 0000 (t,{7'b0,c}) -> hi. CarryOut = k | Over.
//  SHL16: S1 op 0001 (A_lo,1) -> lo, c=Over (A[7]). S2 op 0001 (A_hi,1) -> t, CarryOut=Over (A[15]).
//         S3 op 0100 (t,{7'b0,c}) -> hi.
//  SHR16: S1 op 0010 (A_hi,1) -> hi, c=Over (A[8]). S2 op 0010 (A_lo,1) -> t, CarryOut=Over (A[0]).
//         S3 op 0100 (t,{c,7'b0}) -> lo.
//  MOV16: S1 op 0111 (0,A_lo) -> lo. S2 op 0111 (0,A_hi) -> hi. S3 op 0111 (0,A_hi) -> hi. CarryOut=0.
//  Intermediates (lo, hi, t, c, k) are internal. Result/CarryOut update only at the E3 capture. Mid-op Result holds the previous value.
//  Cmd is sampled only at accept; changes on Cmd mid-op have no effect.
//  Reset mid-op: immediate return to IDLE with reset values; no Done pulse.
//  Wrap-around: ADD16 is modulo 2^16 with carry in CarryOut. Shifts are by exactly 1.
// TESTING
//  ADD16 00FF+0001 -> Result=0100, CarryOut=0, Done exactly 3 edges after accept, Busy high for 3 cycles.
//  ADD16 FFFF+0001 -> Result=0000, CarryOut=1. ADD16 7FFF+0001 -> 8000, CarryOut=0.
//  SHL16 80C0 -> Result=0180, CarryOut=1. SHR16 0181 -> Result=00C0, CarryOut=1.
//  MOV16 A=BEEF, B=1234 -> Result=BEEF, CarryOut=0. Per-cycle AluOp checked: 0111, 0111, 0111.
//  Start with ADD 0001+0001 while busy on ADD 1000+2000 -> ignored, Result=3000. Start in the Done cycle -> accepted, next Done 3 edges later.
//  Reset asserted in S2 -> Busy=0, Result=0, AluOp=0111 before the next edge; no Done; a fresh Start runs normally.

Source files
------------

// File: rtl/alu_wide_seq_if.sv
// Bundle between decode, the wide-op sequencer and the shared 8-bit ALU.
// The slave modport is the sequencer's view; the master modport is the
// environment (decode requester plus the ALU itself).
interface alu_wide_seq_if #(
  parameter int W = 8
);
  logic           Start;
  logic [1:0]     Cmd;
  logic [2*W-1:0] OpA;
  logic [2*W-1:0] OpB;
  logic [W-1:0]   AluA;
  logic [W-1:0]   AluB;
  logic [3:0]     AluOp;
  logic [W-1:0]   AluOut;
  logic           AluOver;
  logic [2*W-1:0] Result;
  logic           CarryOut;
  logic           Busy;
  logic           Done;

  modport slave (
    input  Start, Cmd, OpA, OpB, AluOut, AluOver,
    output AluA, AluB, AluOp, Result, CarryOut, Busy, Done
  );

  modport master (
    output Start, Cmd, OpA, OpB, AluOut, AluOver,
    input  AluA, AluB, AluOp, Result, CarryOut, Busy, Done
  );
endinterface

// File: rtl/alu_wide_seq.sv
// 16-bit ADD/SHL1/SHR1/MOV sequencer built on a shared combinational 8-bit ALU.
// Each wide op is three ALU steps (S1..S3); AluOver carries the inter-byte
// bit between steps, and every step's ALU result is captured on the next edge.
module alu_wide_seq #(
  parameter int         W       = 8,
  parameter logic [3:0] IDLE_OP = 4'b0111
) (
  input  logic          CLK,
  input  logic          Reset,
  alu_wide_seq_if.slave bus
);

  localparam int RW = 2 * W;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SHL = 2'b01;
  localparam logic [1:0] CMD_SHR = 2'b10;
  localparam logic [1:0] CMD_MOV = 2'b11;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SHL = 4'b0001;
  localparam logic [3:0] OP_SHR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } state_t;

  state_t         state_q;
  logic [1:0]     cmd_q;
  logic [RW-1:0]  opa_q;
  logic [RW-1:0]  opb_q;
  logic [W-1:0]   lo_q;      // low result byte (ADD/SHL/MOV)
  logic [W-1:0]   hi_q;      // high result byte (SHR)
  logic [W-1:0]   t_q;       // S2 partial byte finished in S3
  logic           c_q;       // inter-byte carry / shifted bit from S1
  logic           k_q;       // S2 carry (ADD) or shifted-out bit (shifts)
  logic [RW-1:0]  result_q;
  logic           carry_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [3:0]     alu_op;

  logic [W-1:0]   one_lsb;
  logic [W-1:0]   c_lsb;
  logic [W-1:0]   c_msb;

  assign one_lsb = {{(W-1){1'b0}}, 1'b1};
  assign c_lsb   = {{(W-1){1'b0}}, c_q};
  assign c_msb   = {c_q, {(W-1){1'b0}}};

  // ALU operand/opcode selection from the current step and the latched command
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = IDLE_OP;
    unique case (state_q)
      ST_S1: begin
        unique case (cmd_q)
          CMD_ADD: begin alu_op = OP_ADD; alu_a = opa_q[W-1:0];  alu_b = opb_q[W-1:0]; end
          CMD_SHL: begin alu_op = OP_SHL; alu_a = opa_q[W-1:0];  alu_b = one_lsb;      end
          CMD_SHR: begin alu_op = OP_SHR; alu_a = opa_q[RW-1:W]; alu_b = one_lsb;      end
          default: begin alu_op = OP_MOV; alu_a = '0;            alu_b = opa_q[W-1:0]; end
        endcase
      end
      ST_S2: begin
        unique case (cmd_q)
          CMD_ADD: begin alu_op = OP_ADD; alu_a = opa_q[RW-1:W]; alu_b = opb_q[RW-1:W]; end
          CMD_SHL: begin alu_op = OP_SHL; alu_a = opa_q[RW-1:W]; alu_b = one_lsb;       end
          CMD_SHR: begin alu_op = OP_SHR; alu_a = opa_q[W-1:0];  alu_b = one_lsb;       end
          default: begin alu_op = OP_MOV; alu_a = '0;            alu_b = opa_q[RW-1:W]; end
        endcase
      end
      ST_S3: begin
        unique case (cmd_q)
          CMD_ADD: begin alu_op = OP_ADD; alu_a = t_q; alu_b = c_lsb;          end
          CMD_SHL: begin alu_op = OP_OR;  alu_a = t_q; alu_b = c_lsb;          end
          CMD_SHR: begin alu_op = OP_OR;  alu_a = t_q; alu_b = c_msb;          end
          default: begin alu_op = OP_MOV; alu_a = '0;  alu_b = opa_q[RW-1:W]; end
        endcase
      end
      default: ;
    endcase
  end

  // Sequencer FSM: accept, capture each ALU step, publish result with a Done pulse
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_ADD;
      opa_q    <= '0;
      opb_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      t_q      <= '0;
      c_q      <= 1'b0;
      k_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            cmd_q   <= bus.Cmd;
            opa_q   <= bus.OpA;
            opb_q   <= bus.OpB;
            busy_q  <= 1'b1;
            state_q <= ST_S1;
          end
        end
        ST_S1: begin
          // SHR works top byte first so the bit falling out of it enters the low byte
          if (cmd_q == CMD_SHR) hi_q <= bus.AluOut;
          else                  lo_q <= bus.AluOut;
          c_q     <= bus.AluOver;
          state_q <= ST_S2;
        end
        ST_S2: begin
          t_q     <= bus.AluOut;
          k_q     <= bus.AluOver;
          state_q <= ST_S3;
        end
        default: begin
          unique case (cmd_q)
            CMD_ADD: begin result_q <= {bus.AluOut, lo_q}; carry_q <= k_q | bus.AluOver; end
            CMD_SHL: begin result_q <= {bus.AluOut, lo_q}; carry_q <= k_q;               end
            CMD_SHR: begin result_q <= {hi_q, bus.AluOut}; carry_q <= k_q;               end
            default: begin result_q <= {bus.AluOut, lo_q}; carry_q <= 1'b0;              end
          endcase
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.AluA     = alu_a;
  assign bus.AluB     = alu_b;
  assign bus.AluOp    = alu_op;
  assign bus.Result   = result_q;
  assign bus.CarryOut = carry_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: models the shared 8-bit ALU, drives directed and
// random wide ops, and compares against a plain 16-bit arithmetic reference.
module tb_alu_wide_seq;

  logic CLK;
  logic Reset;

  alu_wide_seq_if #(.W(8)) bus ();

  alu_wide_seq #(.W(8), .IDLE_OP(4'b0111)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared ALU behaviour: {Over, Out}
  function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b0001: return {a[7], a[6:0], 1'b0};
      4'b0010: return {a[0], 1'b0, a[7:1]};
      4'b0100: return {1'b0, a | b};
      4'b0111: return {1'b0, b};
      default: return 9'h000;
    endcase
  endfunction

  assign {bus.AluOver, bus.AluOut} = alu_model(bus.AluOp, bus.AluA, bus.AluB);

  // Reference: {CarryOut, Result} of the 16-bit operation
  function automatic logic [16:0] ref_model(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b);
    case (cmd)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {a, 1'b0};
      2'b10:   return {a[0], 1'b0, a[15:1]};
      default: return {1'b0, a};
    endcase
  endfunction

  // Opcode the ALU should see at each of the three steps
  function automatic logic [3:0] exp_op(input logic [1:0] cmd, input int step);
    case (cmd)
      2'b00:   return 4'b0000;
      2'b01:   return (step == 2) ? 4'b0100 : 4'b0001;
      2'b10:   return (step == 2) ? 4'b0100 : 4'b0010;
      default: return 4'b0111;
    endcase
  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_res = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One wide op; Start is raised in the cycle before the accept edge, which
  // for back-to-back calls is the previous op's Done cycle.
  task automatic run_op(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b,
                        input bit inject, input string tag);
    logic [16:0] exp;
    exp = ref_model(cmd, a, b);
    @(negedge CLK);
    bus.Start = 1'b1; bus.Cmd = cmd; bus.OpA = a; bus.OpB = b;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        if (inject) begin
          bus.Start = 1'b1; bus.Cmd = 2'b00; bus.OpA = 16'h0001; bus.OpB = 16'h0001;
        end else begin
          bus.Cmd = 2'($urandom); bus.OpA = 16'($urandom); bus.OpB = 16'($urandom);
        end
      end
      if (k == 1) bus.Start = 1'b0;
      check({tag, "/busy"},  32'(bus.Busy),   32'd1);
      check({tag, "/done"},  32'(bus.Done),   32'd0);
      check({tag, "/op"},    32'(bus.AluOp),  32'(exp_op(cmd, k)));
      check({tag, "/held"},  32'(bus.Result), 32'(last_res));
      @(posedge CLK); #1;
    end
    check({tag, "/done3"},  32'(bus.Done),     32'd1);
    check({tag, "/busy3"},  32'(bus.Busy),     32'd0);
    check({tag, "/res"},    32'(bus.Result),   32'(exp[15:0]));
    check({tag, "/carry"},  32'(bus.CarryOut), 32'(exp[16]));
    check({tag, "/idleop"}, 32'(bus.AluOp),    32'h7);
    last_res = exp[15:0];
  endtask

  initial begin
    bus.Start = 1'b0; bus.Cmd = 2'b00; bus.OpA = '0; bus.OpB = '0;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst/res",   32'(bus.Result),   32'h0);
    check("rst/carry", 32'(bus.CarryOut), 32'h0);
    check("rst/busy",  32'(bus.Busy),     32'h0);
    check("rst/done",  32'(bus.Done),     32'h0);
    check("rst/alua",  32'(bus.AluA),     32'h0);
    check("rst/alub",  32'(bus.AluB),     32'h0);
    check("rst/aluop", 32'(bus.AluOp),    32'h7);
    @(negedge CLK);
    Reset = 1'b0;

    run_op(2'b00, 16'h00FF, 16'h0001, 1'b0, "add_ff_1");
    run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, "add_7fff");
    run_op(2'b01, 16'h80C0, 16'h0000, 1'b0, "shl");
    run_op(2'b10, 16'h0181, 16'h0000, 1'b0, "shr");
    run_op(2'b11, 16'hBEEF, 16'h1234, 1'b0, "mov");
    run_op(2'b00, 16'h1000, 16'h2000, 1'b1, "add_ignore");
    run_op(2'b00, 16'h0001, 16'h0001, 1'b0, "add_in_done");

    // Reset while in S2
    @(negedge CLK);
    bus.Start = 1'b1; bus.Cmd = 2'b00; bus.OpA = 16'h1234; bus.OpB = 16'h4321;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    #1;
    check("rstmid/busy",  32'(bus.Busy),   32'h0);
    check("rstmid/res",   32'(bus.Result), 32'h0);
    check("rstmid/aluop", 32'(bus.AluOp),  32'h7);
    check("rstmid/done",  32'(bus.Done),   32'h0);
    #1;
    Reset = 1'b0;
    last_res = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("rstmid/nodone", 32'(bus.Done), 32'h0);
    end
    run_op(2'b01, 16'h4001, 16'h0000, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), 16'($urandom), 16'($urandom), 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
